// File: rtl/led_top_pkg.sv
// Shared constants for the key-filter / LED-flash demo: default timing for a
// 50 MHz board, the flasher FSM state encodings, and the hold-indicator
// thermometer helper (used only when LED_HOLD_IND_EN is defined).
package led_top_pkg;

  localparam int unsigned CLK_FREQ_HZ      = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYC = CLK_FREQ_HZ / 50;  // 20 ms
  localparam int unsigned DEF_SEC_CYC      = CLK_FREQ_HZ;       // 1 s
  localparam int unsigned DEF_HALF_CYC     = CLK_FREQ_HZ / 4;   // 250 ms
  localparam int unsigned DEF_MAX_FLASH    = 4;

  // Flasher FSM encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  // Lower n bits set: n=2 -> 4'b0011
  function automatic logic [3:0] therm4(input logic [2:0] n);
    logic [3:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n)) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/led_top_led_flash.sv
// led_flash: flashes all four LEDs `count` times once started. Each flash is
// HALF_CYC cycles lit followed by HALF_CYC cycles dark. Starts are accepted
// only in IDLE; flash_done pulses in the last dark cycle of the sequence.
module led_flash
  import led_top_pkg::*;
#(
  parameter int unsigned HALF_CYC = DEF_HALF_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] count,
  output logic [3:0] led,
  output logic       busy,
  output logic       flash_done
);

  localparam int unsigned HW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYC - 1);

  logic [1:0]    r_state;
  logic [HW-1:0] r_half_cnt;
  logic [2:0]    r_n;       // flashes requested for this sequence
  logic [2:0]    r_done;    // flashes completed (counted on ON->OFF)
  logic          w_half_end;
  logic          w_more;

  assign w_half_end = (r_half_cnt == HALF_LAST);
  assign w_more     = (r_done < r_n);

  // FSM: IDLE -> ON -> OFF -> (ON again while flashes remain | IDLE)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_half_cnt <= '0;
      r_n        <= '0;
      r_done     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= ON;
            r_n        <= count;
            r_done     <= '0;
            r_half_cnt <= '0;
          end
        end
        ON: begin
          if (w_half_end) begin
            r_state    <= OFF;
            r_half_cnt <= '0;
            r_done     <= r_done + 3'd1;
          end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
          end
        end
        OFF: begin
          if (w_half_end) begin
            r_half_cnt <= '0;
            r_state    <= w_more ? ON : IDLE;
          end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset darkens the LEDs at once
  assign led        = (r_state == ON) ? 4'b1111 : 4'b0000;
  assign busy       = (r_state != IDLE);
  assign flash_done = (r_state == OFF) && w_half_end && !w_more;

endmodule

// File: rtl/led_top.sv
// led_top: single-key LED flasher. The active-low key is synchronised and
// debounced; the time it is held (whole seconds, saturating) picks how many
// times led_flash blinks all four LEDs after release.
// Optional macro LED_HOLD_IND_EN: while the key is held and the flasher is
// idle, the LEDs show a thermometer of secs+1. Undefined: LEDs dark while held.
module led_top
  import led_top_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned SEC_CYC      = DEF_SEC_CYC,
  parameter int unsigned HALF_CYC     = DEF_HALF_CYC,
  parameter int unsigned MAX_FLASH    = DEF_MAX_FLASH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic [3:0] led
);

  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned SW = (SEC_CYC > 1) ? $clog2(SEC_CYC) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_CYC - 1);
  localparam logic [2:0]    SECS_MAX  = 3'(MAX_FLASH - 1);

  logic          r_key_meta;
  logic          r_key_sync;
  logic          r_key_prev;
  logic [DW-1:0] r_db_cnt;
  logic          r_key_filt;
  logic          r_press;
  logic          r_release;
  logic          r_holding;
  logic [SW-1:0] r_cyc_cnt;
  logic [2:0]    r_secs;
  logic          r_start;
  logic [2:0]    r_count;

  logic [3:0]    w_flash_led;
  logic          w_busy;
  logic          w_flash_done;

  // Two-flop synchroniser; the idle (released) key level is 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_meta <= 1'b1;
      r_key_sync <= 1'b1;
    end else begin
      r_key_meta <= key;
      r_key_sync <= r_key_meta;
    end
  end

  // Debounce: accept the synced level after DEBOUNCE_CYC equal samples and
  // emit one-cycle press/release pulses when the filtered level flips
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_prev <= 1'b1;
      r_db_cnt   <= '0;
      r_key_filt <= 1'b1;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
    end else begin
      r_key_prev <= r_key_sync;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      if (r_key_sync != r_key_prev) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt != DB_LAST) begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end else begin
        r_key_filt <= r_key_sync;
        r_press    <= r_key_filt & ~r_key_sync;
        r_release  <= ~r_key_filt & r_key_sync;
      end
    end
  end

  // Hold measurement from an accepted press to its release; the release
  // launches the flasher with N = secs+1 on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_holding <= 1'b0;
      r_cyc_cnt <= '0;
      r_secs    <= '0;
      r_start   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_start <= 1'b0;
      // r_count only describes the sequence in flight; drop it when it ends
      if (w_flash_done) r_count <= '0;
      if (r_press && !w_busy && !r_holding) begin
        // A press seen while flashing never gets here, so it is not measured
        r_holding <= 1'b1;
        r_cyc_cnt <= '0;
        r_secs    <= '0;
      end else if (r_holding) begin
        if (r_release) begin
          r_holding <= 1'b0;
          r_start   <= 1'b1;
          r_count   <= r_secs + 3'd1;
          r_cyc_cnt <= '0;
          r_secs    <= '0;
        end else if (r_cyc_cnt == SEC_LAST) begin
          r_cyc_cnt <= '0;
          if (r_secs != SECS_MAX) r_secs <= r_secs + 3'd1;
        end else begin
          r_cyc_cnt <= r_cyc_cnt + SW'(1);
        end
      end
    end
  end

  led_flash #(
    .HALF_CYC (HALF_CYC)
  ) led_flash (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (r_start),
    .count      (r_count),
    .led        (w_flash_led),
    .busy       (w_busy),
    .flash_done (w_flash_done)
  );

`ifdef LED_HOLD_IND_EN
  assign led = (r_holding && !w_busy) ? therm4(r_secs + 3'd1) : w_flash_led;
`else
  assign led = w_flash_led;
`endif

endmodule

// File: tb/tb_led_top.sv
// Testbench for led_top with scaled-down timing. Expected flash counts are
// queued when a key press is driven and popped when the flasher reports
// flash_done; a monitor checks every lit/dark period length.
module tb_led_top;

  localparam int unsigned DB   = 20;
  localparam int unsigned SEC  = 1000;
  localparam int unsigned HALF = 100;
  localparam int unsigned MAXF = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key   = 1'b1;
  logic [3:0] led;

  led_top #(
    .DEBOUNCE_CYC (DB),
    .SEC_CYC      (SEC),
    .HALF_CYC     (HALF),
    .MAX_FLASH    (MAXF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .led   (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sb[$];
  int flashes  = 0;
  int rises    = 0;
  int dones    = 0;
  int run_len  = 0;
  logic [3:0] prev_led = 4'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Monitor: period lengths, flash counting and scoreboard pop on flash_done
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len  = 0;
      prev_led = 4'h0;
      flashes  = 0;
    end else begin
      if (led === prev_led) begin
        run_len++;
      end else begin
        if (prev_led == 4'hF) check_eq("on_len", run_len, HALF);
        else if (flashes != 0) check_eq("off_len", run_len, HALF);
        if (led == 4'hF) begin
          flashes++;
          rises++;
        end
        run_len  = 1;
        prev_led = led;
      end
      if (dut.led_flash.flash_done) begin
        dones++;
        check_eq("done_off_len", run_len, HALF);
        if (sb.size() == 0) check_eq("sb_underflow", sb.size(), 1);
        else check_eq("flash_cnt", flashes, sb.pop_front());
        $display("flash sequence done: %0d flashes", flashes);
        flashes = 0;
      end
    end
  end

  // n toggles of 1..3 cycles each; even n returns key to its start level
  task automatic bounce(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) key = ~key;
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
  endtask

  // Bouncy press, hold, bouncy release; returns once the LEDs first light
  task automatic do_press(input int hold, input int exp_n);
    int lat;
    sb.push_back(exp_n);
    $display("press: hold %0d cycles, expect %0d flashes", hold, exp_n);
    bounce(50);
    @(negedge clk) key = 1'b0;
    repeat (hold / 2) @(negedge clk);
    check_eq("hold_led", led, 0);
    repeat (hold - hold / 2) @(negedge clk);
    bounce(50);
    @(negedge clk) key = 1'b1;
    lat = 0;
    while (led != 4'hF && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq("flash_latency_ok", (lat >= DB && lat <= DB + 8), 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("seq_done", sb.size(), 0);
  endtask

  int base_r;
  int base_d;

  initial begin
    // 1. reset
    repeat (20) @(negedge clk);
    check_eq("rst_led", led, 0);
    check_eq("rst_flash_done", dut.led_flash.flash_done, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 2-4. hold times select 1..4 flashes (last one saturates)
    do_press(500, 1);  wait_done(8 * HALF + 200);
    do_press(1500, 2); wait_done(8 * HALF + 200);
    do_press(2500, 3); wait_done(8 * HALF + 200);
    do_press(5000, 4); wait_done(8 * HALF + 200);

    // 5. bouncing only, never stable for the debounce time
    base_r = rises;
    base_d = dones;
    bounce(50);
    @(negedge clk) key = 1'b0;
    repeat (DB - 5) @(negedge clk);
    key = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("bounce_no_flash", rises - base_r, 0);
    check_eq("bounce_no_done", dones - base_d, 0);
    check_eq("bounce_led", led, 0);
    $display("bounce-only: no flash expected");

    // 6a. press while flashing is ignored
    base_r = rises;
    base_d = dones;
    do_press(500, 1);
    @(negedge clk) key = 1'b0;
    repeat (100) @(negedge clk);
    key = 1'b1;
    wait_done(8 * HALF + 200);
    repeat (400) @(negedge clk);
    check_eq("busy_press_rises", rises - base_r, 1);
    check_eq("busy_press_dones", dones - base_d, 1);
    check_eq("busy_press_led", led, 0);
    $display("press during flash: ignored");

    // 6b. reset mid-flash aborts immediately
    do_press(500, 1);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_led", led, 0);
    check_eq("midrst_busy", dut.led_flash.busy, 0);
    sb.delete();
    base_d = dones;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check_eq("midrst_no_done", dones - base_d, 0);
    check_eq("midrst_led_after", led, 0);
    $display("reset mid-flash: aborted");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
